udp_tx_prep: RTL and testbench
==============================

Name: udp_tx_prep

Overview:
- Store-and-forward stage directly upstream of eth_tx.
- Buffers one complete application payload and counts its bytes.
- Computes the ones'-complement sum of the payload, then replays it to eth_tx as a continuous burst.
- app_pkt_len and app_cs are valid from the first beat of the burst, as eth_tx requires for header generation.

Parameters:
- DATA_W, 16, payload beat width in bits; multiple of 16.
- KEEP_W, DATA_W/8, bytes per beat.
- LEN_W, $clog2(KEEP_W+1), width of the per-beat byte count.
- BUF_DEPTH, 1024, buffer depth in beats; BUF_DEPTH*KEEP_W must be at most 65535.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  stage can accept a beat.
- in_data_i  in  DATA_W  payload; byte 0 is in [7:0] and is first on the wire.
- in_len_i  in  LEN_W  valid bytes in the beat; equals KEEP_W except on the last beat.
- in_last_i  in  1  final beat of the packet.
- in_cancel_i  in  1  discard the packet currently being filled.
- app_valid_o  out  1  to eth_tx app_valid_i.
- app_data_o  out  DATA_W  to eth_tx app_data_i.
- app_len_o  out  LEN_W  to eth_tx app_len_i.
- app_pkt_len_o  out  16  payload byte count; to eth_tx app_pkt_len_i.
- app_cs_o  out  16  payload checksum; to eth_tx app_cs_i.
- drop_o  out  1  one-cycle pulse when a packet is discarded.

Behaviour:
- Reset values: all outputs 0 except in_ready_o. nreset asserted mid-operation clears state immediately and truncates any burst in progress; no recovery of the truncated packet.
- After reset release, in_ready_o = 1 (IDLE).
- A beat transfers when in_valid_i & in_ready_o.

States:
- IDLE: ready = 1. The first accepted beat is written at address 0 and moves to FILL, or to DRAIN_WAIT if it has in_last_i.
- FILL: ready = 1. Each beat is written at wr_ptr++, byte count += in_len_i, checksum updated. A beat with in_last_i moves to DRAIN_WAIT.
- DRAIN_WAIT: one cycle; ready = 0; registered buffer read of address 0.
- DRAIN: ready = 0.
  - app_valid_o = 1 for exactly wr_ptr consecutive cycles, with no gaps (eth_tx has no backpressure).
  - app_len_o = KEEP_W except on the final beat, which carries the stored last len.
  - app_pkt_len_o and app_cs_o are stable throughout DRAIN.
  - After the final beat, return to IDLE and clear pointers and accumulators.
- DROP: ready = 1; beats are swallowed until in_last_i, then pulse drop_o and return to IDLE.

Timing:
- Latency: when the last input beat is accepted in cycle N, the first app_valid_o is in cycle N+2.

Checksum:
- Each 16-bit word is {byte 2k, byte 2k+1}.
- Bytes beyond in_len_i are treated as 0, so an odd trailing byte is padded with low byte 00.
- 17-bit accumulator with end-around carry folded every beat.
- Output is the folded sum, not inverted. eth_tx adds the header/pseudo-header and inverts.

Boundary conditions:
- Overflow: a beat arriving when wr_ptr == BUF_DEPTH goes to DROP. If that beat has in_last_i, pulse drop_o and go to IDLE directly.
- Cancel: in_cancel_i in FILL or DROP discards the packet, pulses drop_o and returns to IDLE next cycle.
  - Cancel wins over a simultaneous in_last_i.
  - Cancel alongside the first beat in IDLE discards that beat.
  - Cancel in IDLE without a beat, or in DRAIN_WAIT/DRAIN, is ignored.
- A valid beat with in_len_i = 0 is a protocol violation. It is stored and counted as 0 bytes, with no assertion in RTL.

Optional Feature:
- Macro: UDP_TX_PREP_CS_EN.
- Defined: checksum accumulator present; app_cs_o as described above.
- Undefined: accumulator logic removed; app_cs_o tied 0 (UDP checksum disabled, legal for IPv4). Length and buffering are unchanged.

Decomposition:
- Shared package eth_pkg holds:
  - PKT_LEN_W = 16 and UDP_CS_W = 16.
  - The state enum for this block.
  - Function cs_add(acc, word), ones'-complement add with fold, shared with eth_tx header checksum.
- One sub-module: udp_tx_prep_buf, a simple dual-port RAM of BUF_DEPTH x (DATA_W+LEN_W) with registered read, inferred.

Test Plan:
- Bytes 01 02 03 04 in 2 beats, last len 2 -> 2 output beats starting at N+2, app_pkt_len_o = 4, app_cs_o = 0x0406.
- Bytes 01 02 03 (last beat len 1) -> app_pkt_len_o = 3, app_cs_o = 0x0402, final app_len_o = 1.
- Words FF FF, 00 01 -> app_cs_o = 0x0001 (carry folded), app_pkt_len_o = 4.
- 5-beat packet with in_cancel_i on beat 3 -> no app_valid_o, drop_o pulses once. A following 01 02 03 04 packet gives cs 0x0406.
- BUF_DEPTH = 8, 9-beat packet -> ready stays high, drop_o pulses after the last beat, no output. The next packet is correct.
- nreset low on the 2nd DRAIN beat -> app_valid_o = 0 immediately. After release, ready = 1 and a new packet drains correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet/UDP widths, udp_tx_prep state enum and ones'-complement add
package eth_pkg;

    localparam int PKT_LEN_W = 16;
    localparam int UDP_CS_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN_WAIT,
        ST_DRAIN,
        ST_DROP
    } udp_tx_state_e;

    // Ones'-complement add; one fold is enough because two 16-bit operands
    // can never carry out of the folded result a second time.
    function automatic logic [UDP_CS_W-1:0] cs_add(input logic [UDP_CS_W-1:0] acc,
                                                   input logic [UDP_CS_W-1:0] word);
        logic [UDP_CS_W:0] sum;
        sum = {1'b0, acc} + {1'b0, word};
        return sum[UDP_CS_W-1:0] + {{(UDP_CS_W-1){1'b0}}, sum[UDP_CS_W]};
    endfunction

endpackage

// File: rtl/udp_tx_prep_if.sv
// rtl/udp_tx_prep_if.sv - payload input and eth_tx-facing output signals of udp_tx_prep
interface udp_tx_prep_if #(
    parameter int DATA_W = 16,
    parameter int KEEP_W = DATA_W / 8,
    parameter int LEN_W  = $clog2(KEEP_W + 1)
);
    import eth_pkg::*;

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [DATA_W-1:0]    in_data_i;
    logic [LEN_W-1:0]     in_len_i;
    logic                 in_last_i;
    logic                 in_cancel_i;
    logic                 app_valid_o;
    logic [DATA_W-1:0]    app_data_o;
    logic [LEN_W-1:0]     app_len_o;
    logic [PKT_LEN_W-1:0] app_pkt_len_o;
    logic [UDP_CS_W-1:0]  app_cs_o;
    logic                 drop_o;

    modport master (
        output in_valid_i, in_data_i, in_len_i, in_last_i, in_cancel_i,
        input  in_ready_o, app_valid_o, app_data_o, app_len_o, app_pkt_len_o, app_cs_o, drop_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_len_i, in_last_i, in_cancel_i,
        output in_ready_o, app_valid_o, app_data_o, app_len_o, app_pkt_len_o, app_cs_o, drop_o
    );

endinterface

// File: rtl/udp_tx_prep_buf.sv
// rtl/udp_tx_prep_buf.sv - simple dual-port payload RAM with registered read
module udp_tx_prep_buf #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 18,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port on the same clock; no reset so it maps to block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_tx_prep.sv
// rtl/udp_tx_prep.sv - store-and-forward UDP payload stage; UDP_TX_PREP_CS_EN enables the checksum
module udp_tx_prep
    import eth_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int LEN_W     = $clog2(KEEP_W + 1),
    parameter int BUF_DEPTH = 1024
) (
    input  logic         clk,
    input  logic         nreset,
    udp_tx_prep_if.slave bus
);

    localparam int AW    = $clog2(BUF_DEPTH);
    localparam int PTR_W = $clog2(BUF_DEPTH + 1);
    localparam int MEM_W = DATA_W + LEN_W;

    udp_tx_state_e        state, state_n;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_cnt;
    logic [PKT_LEN_W-1:0] byte_cnt;
    logic                 drop_q;

    logic                 ready;
    logic                 wr_en;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic                 clr;
    logic                 drop_n;
    logic                 last_out;
    logic [MEM_W-1:0]     rd_q;

    assign last_out = (rd_cnt == wr_ptr - PTR_W'(1));

    udp_tx_prep_buf #(
        .DEPTH(BUF_DEPTH),
        .WIDTH(MEM_W),
        .AW   (AW)
    ) u_buf (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr[AW-1:0]),
        .wr_data({bus.in_len_i, bus.in_data_i}),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_q)
    );

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle control: accept/write, drain reads, discard and clear
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = AW'(rd_cnt + PTR_W'(1));
        clr     = 1'b0;
        drop_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.in_valid_i) begin
                    if (bus.in_cancel_i) begin
                        drop_n = 1'b1;
                        clr    = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        state_n = bus.in_last_i ? ST_DRAIN_WAIT : ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                ready = 1'b1;
                if (bus.in_cancel_i) begin
                    drop_n  = 1'b1;
                    clr     = 1'b1;
                    state_n = ST_IDLE;
                end else if (bus.in_valid_i) begin
                    if (wr_ptr == PTR_W'(BUF_DEPTH)) begin
                        if (bus.in_last_i) begin
                            drop_n  = 1'b1;
                            clr     = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_DROP;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (bus.in_last_i) begin
                            state_n = ST_DRAIN_WAIT;
                        end
                    end
                end
            end
            ST_DRAIN_WAIT: begin
                rd_en   = 1'b1;
                rd_addr = '0;
                state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                rd_en = 1'b1;
                if (last_out) begin
                    clr     = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_DROP: begin
                ready = 1'b1;
                if (bus.in_cancel_i || (bus.in_valid_i && bus.in_last_i)) begin
                    drop_n  = 1'b1;
                    clr     = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Write pointer, byte count, drain read counter and drop pulse
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr   <= '0;
            rd_cnt   <= '0;
            byte_cnt <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= drop_n;
            if (clr) begin
                wr_ptr   <= '0;
                rd_cnt   <= '0;
                byte_cnt <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                    byte_cnt <= byte_cnt + PKT_LEN_W'(bus.in_len_i);
                end
                if (state == ST_DRAIN_WAIT) begin
                    rd_cnt <= '0;
                end else if (state == ST_DRAIN) begin
                    rd_cnt <= rd_cnt + PTR_W'(1);
                end
            end
        end
    end

`ifdef UDP_TX_PREP_CS_EN
    logic [UDP_CS_W-1:0] cs_acc;
    logic [UDP_CS_W-1:0] cs_next;
    logic [7:0]          b_hi;
    logic [7:0]          b_lo;

    // Fold every 16-bit word of the beat into the running sum; bytes past in_len count as zero
    always_comb begin
        cs_next = cs_acc;
        b_hi    = 8'h00;
        b_lo    = 8'h00;
        for (int k = 0; k < KEEP_W / 2; k++) begin
            b_hi    = (LEN_W'(2 * k) < bus.in_len_i) ? bus.in_data_i[16*k +: 8] : 8'h00;
            b_lo    = (LEN_W'(2 * k + 1) < bus.in_len_i) ? bus.in_data_i[16*k+8 +: 8] : 8'h00;
            cs_next = cs_add(cs_next, {b_hi, b_lo});
        end
    end

    // Checksum accumulator, cleared with the packet
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cs_acc <= '0;
        end else if (clr) begin
            cs_acc <= '0;
        end else if (wr_en) begin
            cs_acc <= cs_next;
        end
    end

    assign bus.app_cs_o = cs_acc;
`else
    assign bus.app_cs_o = '0;
`endif

    assign bus.in_ready_o    = ready;
    assign bus.app_valid_o   = (state == ST_DRAIN);
    assign bus.app_data_o    = (state == ST_DRAIN) ? rd_q[DATA_W-1:0] : '0;
    assign bus.app_len_o     = (state != ST_DRAIN) ? '0 :
                               (last_out ? rd_q[MEM_W-1:DATA_W] : LEN_W'(KEEP_W));
    assign bus.app_pkt_len_o = byte_cnt;
    assign bus.drop_o        = drop_q;

endmodule

// File: tb/tb_udp_tx_prep.sv
// tb/tb_udp_tx_prep.sv - self-checking bench for udp_tx_prep with a byte-level reference model
module tb_udp_tx_prep;

`ifdef UDP_TX_PREP_CS_EN
    localparam logic [15:0] CS_MASK = 16'hFFFF;
`else
    localparam logic [15:0] CS_MASK = 16'h0000;
`endif

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   drop_cnt = 0;

    logic [7:0]  pkt [$];
    logic [15:0] m_data [$];
    logic [1:0]  m_len [$];
    logic [15:0] m_plen [$];
    logic [15:0] m_cs [$];
    int          m_cyc [$];

    udp_tx_prep_if #(.DATA_W(16)) bus ();

    udp_tx_prep #(.DATA_W(16), .BUF_DEPTH(8)) dut (
        .clk   (clk),
        .nreset(nreset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nreset) begin
            if (bus.app_valid_o) begin
                m_data.push_back(bus.app_data_o);
                m_len.push_back(bus.app_len_o);
                m_plen.push_back(bus.app_pkt_len_o);
                m_cs.push_back(bus.app_cs_o);
                m_cyc.push_back(cyc);
            end
            if (bus.drop_o) drop_cnt++;
        end
    end

    function automatic logic [15:0] model_cs();
        int unsigned s = 0;
        for (int i = 0; i < pkt.size(); i += 2)
            s += {pkt[i], (i + 1 < pkt.size()) ? pkt[i+1] : 8'h00};
        while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
        return s[15:0] & CS_MASK;
    endfunction

    task automatic clear_mon();
        m_data.delete(); m_len.delete(); m_plen.delete(); m_cs.delete(); m_cyc.delete();
        drop_cnt = 0;
    endtask

    task automatic fill_random(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic send_pkt(input int cancel_at, output int last_cyc, output int stalls);
        int nb;
        int budget;
        nb = (pkt.size() + 1) / 2;
        stalls = 0;
        last_cyc = -1;
        @(posedge clk); #1;
        for (int i = 0; i < nb; i++) begin
            budget = 0;
            while (!bus.in_ready_o && budget < 50) begin
                @(posedge clk); #1;
                budget++; stalls++;
            end
            if (!bus.in_ready_o) begin
                checks++; errors++;
                $display("FAIL ready_timeout got 0 want 1");
                break;
            end
            bus.in_valid_i  = 1'b1;
            bus.in_data_i   = {(2*i+1 < pkt.size()) ? pkt[2*i+1] : 8'h00, pkt[2*i]};
            bus.in_len_i    = (2*i+1 < pkt.size()) ? 2'd2 : 2'd1;
            bus.in_last_i   = (i == nb - 1);
            bus.in_cancel_i = (i == cancel_at);
            last_cyc = cyc;
            @(posedge clk); #1;
            bus.in_valid_i  = 1'b0;
            bus.in_last_i   = 1'b0;
            bus.in_cancel_i = 1'b0;
            if (i == cancel_at) break;
        end
    endtask

    task automatic test_reset();
        bus.in_valid_i = 0; bus.in_data_i = 0; bus.in_len_i = 0;
        bus.in_last_i = 0; bus.in_cancel_i = 0;
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.app_valid_o !== 1'b0 || bus.drop_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b drop=%b want 1 0 0",
                     bus.in_ready_o, bus.app_valid_o, bus.drop_o);
        end
        checks++;
        if (bus.app_data_o !== 16'h0 || bus.app_len_o !== 2'd0 ||
            bus.app_pkt_len_o !== 16'h0 || bus.app_cs_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got d=%h l=%0d pl=%0d cs=%h want all 0",
                     bus.app_data_o, bus.app_len_o, bus.app_pkt_len_o, bus.app_cs_o);
        end
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", bus.in_ready_o);
        end
    endtask

    task automatic test_packets();
        int last_cyc, stalls, nb;
        logic [15:0] ed, want_cs;
        logic [1:0]  el;
        for (int t = 0; t < 16; t++) begin
            case (t)
                0: pkt = '{8'h01, 8'h02, 8'h03, 8'h04};
                1: pkt = '{8'h01, 8'h02, 8'h03};
                2: pkt = '{8'hFF, 8'hFF, 8'h00, 8'h01};
                3: fill_random(16);
                4: fill_random(1);
                default: fill_random($urandom_range(1, 16));
            endcase
            case (t)
                0: want_cs = 16'h0406 & CS_MASK;
                1: want_cs = 16'h0402 & CS_MASK;
                2: want_cs = 16'h0001 & CS_MASK;
                default: want_cs = model_cs();
            endcase
            nb = (pkt.size() + 1) / 2;
            clear_mon();
            send_pkt(-1, last_cyc, stalls);
            repeat (nb + 6) @(posedge clk);
            #1;
            checks++;
            if (m_data.size() != nb) begin
                errors++;
                $display("FAIL pkt%0d_beats got %0d want %0d", t, m_data.size(), nb);
            end else begin
                for (int i = 0; i < nb; i++) begin
                    ed = {(2*i+1 < pkt.size()) ? pkt[2*i+1] : 8'h00, pkt[2*i]};
                    el = (2*i+1 < pkt.size()) ? 2'd2 : 2'd1;
                    checks++;
                    if (m_data[i] !== ed || m_len[i] !== el) begin
                        errors++;
                        $display("FAIL pkt%0d_beat%0d got d=%h l=%0d want d=%h l=%0d",
                                 t, i, m_data[i], m_len[i], ed, el);
                    end
                    checks++;
                    if (m_plen[i] !== 16'(pkt.size()) || m_cs[i] !== want_cs) begin
                        errors++;
                        $display("FAIL pkt%0d_meta%0d got len=%0d cs=%h want len=%0d cs=%h",
                                 t, i, m_plen[i], m_cs[i], pkt.size(), want_cs);
                    end
                    checks++;
                    if (m_cyc[i] != last_cyc + 2 + i) begin
                        errors++;
                        $display("FAIL pkt%0d_timing%0d got cyc %0d want %0d",
                                 t, i, m_cyc[i], last_cyc + 2 + i);
                    end
                end
            end
            checks++;
            if (drop_cnt != 0) begin
                errors++;
                $display("FAIL pkt%0d_drop got %0d want 0", t, drop_cnt);
            end
        end
    endtask

    task automatic test_cancel();
        int last_cyc, stalls;
        int cancel_pos [3] = '{0, 2, 2};
        int cancel_len [3] = '{2, 10, 6};
        clear_mon();
        @(posedge clk); #1;
        bus.in_cancel_i = 1'b1;
        @(posedge clk); #1;
        bus.in_cancel_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (drop_cnt != 0 || bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL cancel_idle got drop=%0d rdy=%b want 0 1", drop_cnt, bus.in_ready_o);
        end
        for (int c = 0; c < 3; c++) begin
            fill_random(cancel_len[c]);
            clear_mon();
            send_pkt(cancel_pos[c], last_cyc, stalls);
            repeat (8) @(posedge clk);
            #1;
            checks++;
            if (m_data.size() != 0 || drop_cnt != 1) begin
                errors++;
                $display("FAIL cancel%0d got beats=%0d drops=%0d want 0 1", c, m_data.size(), drop_cnt);
            end
        end
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04};
        clear_mon();
        send_pkt(-1, last_cyc, stalls);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (m_data.size() != 2 || m_plen[0] !== 16'd4 || m_cs[0] !== (16'h0406 & CS_MASK)) begin
            errors++;
            $display("FAIL cancel_after got beats=%0d want 2 len 4 cs %h", m_data.size(), 16'h0406 & CS_MASK);
        end
    endtask

    task automatic test_overflow();
        int last_cyc, stalls;
        fill_random(18);
        clear_mon();
        send_pkt(-1, last_cyc, stalls);
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL overflow_ready got %0d stalls want 0", stalls);
        end
        checks++;
        if (m_data.size() != 0 || drop_cnt != 1) begin
            errors++;
            $display("FAIL overflow_drop got beats=%0d drops=%0d want 0 1", m_data.size(), drop_cnt);
        end
        fill_random(5);
        clear_mon();
        send_pkt(-1, last_cyc, stalls);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (m_data.size() != 3 || m_plen[0] !== 16'd5 || m_cs[0] !== model_cs() || m_len[2] !== 2'd1) begin
            errors++;
            $display("FAIL overflow_after got beats=%0d want 3 len 5 cs %h", m_data.size(), model_cs());
        end
    endtask

    task automatic test_reset_mid();
        int last_cyc, stalls, budget;
        fill_random(8);
        clear_mon();
        send_pkt(-1, last_cyc, stalls);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!bus.app_valid_o && budget < 10);
        checks++;
        if (!bus.app_valid_o) begin
            errors++;
            $display("FAIL rstmid_start got valid 0 want 1");
        end
        @(posedge clk); #2;
        nreset = 1'b0;
        #1;
        checks++;
        if (bus.app_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.app_pkt_len_o !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got vld=%b rdy=%b pl=%0d want 0 1 0",
                     bus.app_valid_o, bus.in_ready_o, bus.app_pkt_len_o);
        end
        @(negedge clk); #1;
        nreset = 1'b1;
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04};
        clear_mon();
        send_pkt(-1, last_cyc, stalls);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (m_data.size() != 2 || m_plen[1] !== 16'd4 || m_cs[1] !== (16'h0406 & CS_MASK) ||
            m_cyc[0] != last_cyc + 2) begin
            errors++;
            $display("FAIL rstmid_after got beats=%0d want 2 len 4 cs %h", m_data.size(), 16'h0406 & CS_MASK);
        end
    endtask

    task automatic test_back_to_back();
        int last_cyc, stalls, nb1, nb2, len1;
        logic [15:0] cs1;
        fill_random($urandom_range(3, 16));
        nb1 = (pkt.size() + 1) / 2;
        len1 = pkt.size();
        cs1 = model_cs();
        clear_mon();
        send_pkt(-1, last_cyc, stalls);
        fill_random($urandom_range(1, 16));
        nb2 = (pkt.size() + 1) / 2;
        send_pkt(-1, last_cyc, stalls);
        repeat (nb2 + 6) @(posedge clk);
        #1;
        checks++;
        if (m_data.size() != nb1 + nb2) begin
            errors++;
            $display("FAIL b2b_beats got %0d want %0d", m_data.size(), nb1 + nb2);
        end else begin
            checks++;
            if (m_plen[0] !== 16'(len1) || m_cs[0] !== cs1 ||
                m_plen[nb1] !== 16'(pkt.size()) || m_cs[nb1] !== model_cs()) begin
                errors++;
                $display("FAIL b2b_meta got %0d/%h %0d/%h want %0d/%h %0d/%h", m_plen[0], m_cs[0],
                         m_plen[nb1], m_cs[nb1], len1, cs1, pkt.size(), model_cs());
            end
            checks++;
            if (m_cyc[nb1] != last_cyc + 2) begin
                errors++;
                $display("FAIL b2b_latency got %0d want %0d", m_cyc[nb1], last_cyc + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_packets();
        test_cancel();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
